result_reader: RTL and testbench

- Readout engine for the READ_RESULT command. The matrix controller writes result words into the result memory; this block reads them back out.
- It streams a header word, then `count` result words from the result memory, to the SPI transmit path over a valid/ready bus.
- It sits between the result memory read port and the bus_2_spi direction of the SPI bridge. Sequencing is driven by the controller's start/abort.

---
 rtl/result_pkg.sv | 23 ++
 rtl/result_fifo.sv | 71 +++++++
 rtl/result_reader.sv | 138 +++++++++++++
 tb/tb_result_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/result_pkg.sv
// Shared definitions for the READ_RESULT readout path.
//   - Command opcodes used in header words.
//   - rd_state_t : readout FSM states.
//   - make_header: builds the {opcode, 4'h0, count} header word.
package result_pkg;

  localparam logic [3:0] START_CAL   = 4'h3;
  localparam logic [3:0] WRITE_VEC   = 4'h4;
  localparam logic [3:0] WRITE_MAT   = 4'h5;
  localparam logic [3:0] READ_RESULT = 4'h6;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    STREAM,
    DONE
  } rd_state_t;

  function automatic logic [15:0] make_header(input logic [3:0] op, input logic [7:0] cnt);
    return {op, 4'h0, cnt};
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO used to prefetch result words ahead of the SPI side.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write a word (ignored when full)
//   pop        : drop the head word (ignored when empty)
//   flush      : synchronous empty, wins over push/pop
//   dout       : head word, read straight from the storage registers
//   empty, full, count : occupancy status
module result_fifo #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 push,
  input  logic                                 pop,
  input  logic                                 flush,
  input  logic [WORD_SIZE-1:0]                 din,
  output logic [WORD_SIZE-1:0]                 dout,
  output logic                                 empty,
  output logic                                 full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(FIFO_DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CntW'(FIFO_DEPTH));
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem_q[rd_ptr_q];
    count   = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/result_reader.sv
// READ_RESULT readout engine: sends a header word, then `count` words read from
// the result memory, over a valid/ready bus toward the SPI transmit path.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   start, abort             : controller sequencing (abort wins)
//   base_addr, count         : first address and word count, captured on start
//   mem_r_en/addr/data       : result memory read port (1-cycle read latency)
//   tx_data/valid, tx_ready  : stream toward SPI
//   busy, done               : status; done pulses once after the last word
module result_reader #(
  parameter int unsigned ADDR_SIZE   = 10,
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [3:0]  READ_RESULT = 4'h6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_SIZE-1:0] base_addr,
  input  logic [7:0]           count,
  output logic                 mem_r_en,
  output logic [ADDR_SIZE-1:0] mem_r_addr,
  input  logic [WORD_SIZE-1:0] mem_r_data,
  output logic [WORD_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  import result_pkg::*;

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  rd_state_t            state_q;
  logic [ADDR_SIZE-1:0] rd_addr_q;
  logic [7:0]           cnt_q, issued_q, sent_q;
  logic                 inflight_q;

  logic                 fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
  logic [WORD_SIZE-1:0] fifo_head;
  logic [CntW-1:0]      fifo_count;
  logic                 active, credit, xfer;

  always_comb begin
    active = (state_q == HEADER) || (state_q == STREAM);
    // Reads already queued or in flight must never exceed the FIFO space.
    credit     = (32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH;
    mem_r_en   = active && credit && (issued_q < cnt_q);
    mem_r_addr = mem_r_en ? rd_addr_q : '0;

    tx_valid = 1'b0;
    tx_data  = '0;
    case (state_q)
      HEADER: begin
        tx_valid = 1'b1;
        tx_data  = WORD_SIZE'(make_header(READ_RESULT, cnt_q));
      end
      STREAM: begin
        tx_valid = !fifo_empty;
        tx_data  = fifo_empty ? '0 : fifo_head;
      end
      default: ;
    endcase

    xfer       = tx_valid && tx_ready;
    fifo_push  = inflight_q;
    fifo_pop   = (state_q == STREAM) && xfer;
    fifo_flush = abort;
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
  end

  result_fifo #(
    .WORD_SIZE (WORD_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .pop  (fifo_pop),
    .flush(fifo_flush),
    .din  (mem_r_data),
    .dout (fifo_head),
    .empty(fifo_empty),
    .full (fifo_full),
    .count(fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      cnt_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
    end else if (abort) begin
      // Dropping inflight discards the read data that returns next cycle.
      state_q    <= IDLE;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= mem_r_en;
      if (mem_r_en) begin
        rd_addr_q <= rd_addr_q + ADDR_SIZE'(1);
        issued_q  <= issued_q + 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            rd_addr_q <= base_addr;
            cnt_q     <= count;
            issued_q  <= '0;
            sent_q    <= '0;
            state_q   <= HEADER;
          end
        end
        HEADER: begin
          if (xfer) state_q <= (cnt_q != 8'd0) ? STREAM : DONE;
        end
        STREAM: begin
          if (xfer) begin
            sent_q <= sent_q + 8'd1;
            if (sent_q + 8'd1 == cnt_q) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The credit check above keeps returning data from ever landing on a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full && !fifo_flush))
    else $error("result_reader: push into full prefetch FIFO");

endmodule

// File: tb/tb_result_reader.sv
module tb_result_reader;

  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        tx_ready = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [7:0]  count = '0;
  logic        mem_r_en;
  logic [9:0]  mem_r_addr;
  logic [15:0] mem_r_data;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  logic [15:0] mem [1024];

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] xfer_q[$];
  logic [9:0]  addr_q[$];
  logic [31:0] xfer_mask, done_mask, busy_mask, valid_mask, ren_mask;
  int          done_cnt, stall_err, credit_err, abort_cyc;

  result_reader #(
    .ADDR_SIZE  (10),
    .WORD_SIZE  (16),
    .FIFO_DEPTH (FD),
    .READ_RESULT(4'h6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .count     (count),
    .mem_r_en  (mem_r_en),
    .mem_r_addr(mem_r_addr),
    .mem_r_data(mem_r_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Memory model: data is only meaningful the cycle after a read strobe.
  always @(posedge clk) mem_r_data <= mem_r_en ? mem[mem_r_addr] : 16'hDEAD;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_seq(input string tag, input logic [15:0] exp[$]);
    check_eq({tag, "_len"}, xfer_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < xfer_q.size(); i++)
      check_eq($sformatf("%s[%0d]", tag, i), xfer_q[i], exp[i]);
  endtask

  // Cycle 0 carries start; cycles 1..ncyc are observed at the falling edge.
  // mode 0: ready always, 1: ready on odd cycles, 2: ready in cycle 1 and from cycle 10.
  task automatic run(input logic [9:0] base, input logic [7:0] cnt, input int mode,
                     input int abort_after, input int restart_at, input int ncyc);
    logic        prev_stall;
    logic [15:0] prev_data;
    int          issued, data_x;
    xfer_q.delete();
    addr_q.delete();
    xfer_mask = '0; done_mask = '0; busy_mask = '0; valid_mask = '0; ren_mask = '0;
    done_cnt = 0; stall_err = 0; credit_err = 0; abort_cyc = 0;
    prev_stall = 1'b0; prev_data = '0; issued = 0; data_x = 0;
    @(negedge clk);
    base_addr = base; count = cnt; start = 1'b1; tx_ready = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (c == restart_at) begin
        start = 1'b1; base_addr = 10'h3F0; count = 8'd1;
      end
      case (mode)
        1:       tx_ready = c[0];
        2:       tx_ready = (c == 1) || (c >= 10);
        default: tx_ready = 1'b1;
      endcase
      if (abort_after > 0 && abort_cyc == 0 && data_x == abort_after) begin
        abort = 1'b1; abort_cyc = c; tx_ready = 1'b0;
      end
      if (c < 32) begin
        busy_mask[c]  = busy;
        done_mask[c]  = done;
        valid_mask[c] = tx_valid;
        ren_mask[c]   = mem_r_en;
        xfer_mask[c]  = tx_valid && tx_ready;
      end
      if (done) done_cnt++;
      if (prev_stall && (!tx_valid || tx_data != prev_data)) stall_err++;
      prev_stall = tx_valid && !tx_ready && !abort;
      prev_data  = tx_data;
      if (mem_r_en) begin
        if (issued - data_x >= FD) credit_err++;
        addr_q.push_back(mem_r_addr);
        issued++;
      end
      if (tx_valid && tx_ready) begin
        if (xfer_q.size() > 0) data_x++;
        xfer_q.push_back(tx_data);
      end
      if (abort_cyc != 0 && c == abort_cyc + 1) break;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_tx_valid"}, tx_valid, 0);
    check_eq({tag, "_tx_data"}, tx_data, 0);
    check_eq({tag, "_mem_r_en"}, mem_r_en, 0);
    check_eq({tag, "_mem_r_addr"}, mem_r_addr, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
  endtask

  initial begin
    logic [15:0] exp[$];

    for (int i = 0; i < 1024; i++) mem[i] = 16'h5000 + 16'(i);
    mem[10'h010] = 16'hA0A0; mem[10'h011] = 16'hA1A1;
    mem[10'h012] = 16'hA2A2; mem[10'h013] = 16'hA3A3;
    mem[10'h3FE] = 16'hBEEF; mem[10'h3FF] = 16'hCAFE; mem[10'h000] = 16'hF00D;
    mem[10'h200] = 16'h1234;

    #1 rst_n = 1'b0;
    #1 check_idle_outputs("reset");
    #11 rst_n = 1'b1;

    // Basic stream with ready held high.
    run(10'h010, 8'd4, 0, 0, 0, 10);
    exp = '{16'h6004, 16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3};
    check_seq("basic_seq", exp);
    check_eq("basic_xfer_cycles", xfer_mask, 32'h0000_007A);
    check_eq("basic_done_cycle", done_mask, 32'h0000_0080);
    check_eq("basic_busy_cycles", busy_mask, 32'h0000_00FE);
    check_eq("basic_reads", addr_q.size(), 4);
    if (addr_q.size() == 4) begin
      check_eq("basic_addr0", addr_q[0], 10'h010);
      check_eq("basic_addr3", addr_q[3], 10'h013);
    end

    // Ready toggling every cycle.
    run(10'h010, 8'd4, 1, 0, 0, 14);
    check_seq("toggle_seq", exp);
    check_eq("toggle_xfer_cycles", xfer_mask, 32'h0000_02AA);
    check_eq("toggle_done_cycle", done_mask, 32'h0000_0400);
    check_eq("toggle_stall_stable", stall_err, 0);
    check_eq("toggle_credit", credit_err, 0);

    // Long back-pressure: prefetch must stop at four outstanding words.
    run(10'h040, 8'd8, 2, 0, 0, 30);
    exp.delete();
    exp.push_back(16'h6008);
    for (int k = 0; k < 8; k++) exp.push_back(mem[10'h040 + k]);
    check_seq("hold_seq", exp);
    check_eq("hold_credit", credit_err, 0);
    check_eq("hold_stall_stable", stall_err, 0);
    check_eq("hold_reads_first", ren_mask[4:1], 4'hF);
    check_eq("hold_reads_blocked", ren_mask[9:5], 5'h00);
    check_eq("hold_done_count", done_cnt, 1);

    // Zero-length read.
    run(10'h020, 8'd0, 0, 0, 0, 6);
    exp = '{16'h6000};
    check_seq("zero_seq", exp);
    check_eq("zero_done_cycle", done_mask, 32'h0000_0004);
    check_eq("zero_busy_cycles", busy_mask, 32'h0000_0006);
    check_eq("zero_no_reads", ren_mask, 0);

    // Address wrap at the top of memory.
    run(10'h3FE, 8'd3, 0, 0, 0, 10);
    exp = '{16'h6003, 16'hBEEF, 16'hCAFE, 16'hF00D};
    check_seq("wrap_seq", exp);
    check_eq("wrap_reads", addr_q.size(), 3);
    if (addr_q.size() == 3) begin
      check_eq("wrap_addr0", addr_q[0], 10'h3FE);
      check_eq("wrap_addr1", addr_q[1], 10'h3FF);
      check_eq("wrap_addr2", addr_q[2], 10'h000);
    end
    check_eq("wrap_done_cycle", done_mask, 32'h0000_0040);

    // Abort after the second data word, then an immediate clean restart.
    run(10'h100, 8'd8, 0, 2, 0, 20);
    exp = '{16'h6008, mem[10'h100], mem[10'h101]};
    check_seq("abort_seq", exp);
    check_eq("abort_cycle", abort_cyc, 5);
    check_eq("abort_valid_after", valid_mask[6], 0);
    check_eq("abort_busy_after", busy_mask[6], 0);
    check_eq("abort_read_after", ren_mask[6], 0);
    check_eq("abort_no_done", done_cnt, 0);
    run(10'h200, 8'd1, 0, 0, 0, 8);
    exp = '{16'h6001, 16'h1234};
    check_seq("post_abort_seq", exp);
    check_eq("post_abort_done_cycle", done_mask, 32'h0000_0010);

    // Asynchronous reset in the middle of a stream.
    @(negedge clk);
    base_addr = 10'h010; count = 8'd8; start = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Normal run after reset, with a start pulse while busy that must be ignored.
    run(10'h010, 8'd2, 0, 0, 3, 8);
    exp = '{16'h6002, 16'hA0A0, 16'hA1A1};
    check_seq("restart_seq", exp);
    check_eq("restart_done_cycle", done_mask, 32'h0000_0020);
    check_eq("restart_reads", addr_q.size(), 2);
    check_eq("restart_done_count", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
